// File: rtl/mmio_uart_tx_pkg.sv
// rtl/mmio_uart_tx_pkg.sv - shared types and constants for the memory-mapped UART transmitter
//   e_uart_state     : frame state machine encoding
//   UART_*_ADDR      : register addresses on the CPU data bus
//   STAT_*_BIT       : bit positions inside the status register
//   UART_DIV_RESET   : baud divisor after reset (clocks per bit minus 1)
package mmio_uart_tx_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } e_uart_state;

  localparam logic [7:0] UART_DATA_ADDR = 8'hFF;
  localparam logic [7:0] UART_STAT_ADDR = 8'hFE;
  localparam logic [7:0] UART_DIV_ADDR  = 8'hFD;

  localparam int STAT_EMPTY_BIT  = 0;
  localparam int STAT_FULL_BIT   = 1;
  localparam int STAT_ACTIVE_BIT = 2;
  localparam int STAT_OVF_BIT    = 3;

  localparam logic [7:0] UART_DIV_RESET = 8'd15;

endpackage

// File: rtl/mmio_uart_tx_sync_fifo.sv
// rtl/mmio_uart_tx_sync_fifo.sv - synchronous circular-buffer FIFO with first-word fall-through head
//   clk, rst    : clock, synchronous active-low reset (empties the FIFO)
//   push, din   : write request and data; ignored while full
//   pop         : read request; ignored while empty
//   dout        : current head entry (combinational)
//   full, empty : occupancy flags
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  // Pointers carry one extra lap bit so full and empty are distinguishable
  // when the index bits coincide.
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic             do_push;
  logic             do_pop;

  assign empty   = (wr_ptr_q == rd_ptr_q);
  assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    mem_d    = mem_q;
    if (do_push) begin
      mem_d[wr_ptr_q[AW-1:0]] = din;
      wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, 1'b1};
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage needs no reset: entries are only visible between push and pop.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/mmio_uart_tx.sv
// rtl/mmio_uart_tx.sv - memory-mapped 8N1 UART transmitter with TX FIFO, status and divisor registers
//   clk, rst     : clock, synchronous active-low reset
//   mem_addr     : CPU data address
//   mem_wr_en    : CPU store strobe
//   mem_wr_data  : CPU store data
//   mem_rd_data  : register read data, combinational from mem_addr
//   sel          : high when mem_addr hits one of this block's registers
//   tx           : serial line, idles high
//   busy         : frame in progress or FIFO non-empty
module mmio_uart_tx
  import mmio_uart_tx_pkg::*;
#(
  parameter logic [7:0] DATA_ADDR  = UART_DATA_ADDR,
  parameter logic [7:0] STAT_ADDR  = UART_STAT_ADDR,
  parameter logic [7:0] DIV_ADDR   = UART_DIV_ADDR,
  parameter int         FIFO_DEPTH = 4,
  parameter logic [7:0] DIV_RESET  = UART_DIV_RESET
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] mem_addr,
  input  logic       mem_wr_en,
  input  logic [7:0] mem_wr_data,
  output logic [7:0] mem_rd_data,
  output logic       sel,
  output logic       tx,
  output logic       busy
);

  e_uart_state state_q, state_d;
  logic [7:0]  div_q, div_d;
  logic [7:0]  clk_cnt_q, clk_cnt_d;
  logic [2:0]  bit_idx_q, bit_idx_d;
  logic [7:0]  shift_q, shift_d;
  logic        tx_q, tx_d;
  logic        ovf_q, ovf_d;

  logic        wr_data_hit;
  logic        wr_stat_hit;
  logic        wr_div_hit;
  logic        fifo_pop;
  logic        fifo_full;
  logic        fifo_empty;
  logic [7:0]  fifo_dout;
  logic        active;
  logic        bit_done;
  logic [7:0]  stat;

  assign wr_data_hit = mem_wr_en && (mem_addr == DATA_ADDR);
  assign wr_stat_hit = mem_wr_en && (mem_addr == STAT_ADDR);
  assign wr_div_hit  = mem_wr_en && (mem_addr == DIV_ADDR);

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_tx_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (wr_data_hit),
    .pop   (fifo_pop),
    .din   (mem_wr_data),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign active = (state_q != IDLE);
  assign busy   = active || !fifo_empty;
  assign tx     = tx_q;

  // >= rather than == so that lowering div below the running count ends
  // the current bit instead of waiting for the counter to wrap.
  assign bit_done = (clk_cnt_q >= div_q);

  always_comb begin
    stat                  = '0;
    stat[STAT_EMPTY_BIT]  = fifo_empty;
    stat[STAT_FULL_BIT]   = fifo_full;
    stat[STAT_ACTIVE_BIT] = active;
    stat[STAT_OVF_BIT]    = ovf_q;
  end

  always_comb begin
    mem_rd_data = '0;
    sel         = 1'b0;
    if (mem_addr == DATA_ADDR) begin
      sel = 1'b1;
    end else if (mem_addr == STAT_ADDR) begin
      sel         = 1'b1;
      mem_rd_data = stat;
    end else if (mem_addr == DIV_ADDR) begin
      sel         = 1'b1;
      mem_rd_data = div_q;
    end
  end

  // A drop is ordered after the clear so a same-edge drop keeps the flag set.
  always_comb begin
    ovf_d = ovf_q;
    div_d = div_q;
    if (wr_stat_hit && mem_wr_data[STAT_OVF_BIT]) ovf_d = 1'b0;
    if (wr_data_hit && fifo_full)                 ovf_d = 1'b1;
    if (wr_div_hit)                               div_d = mem_wr_data;
  end

  always_comb begin
    state_d   = state_q;
    clk_cnt_d = clk_cnt_q + 8'd1;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    tx_d      = tx_q;
    fifo_pop  = 1'b0;
    unique case (state_q)
      IDLE: begin
        tx_d      = 1'b1;
        clk_cnt_d = '0;
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          shift_d  = fifo_dout;
          tx_d     = 1'b0;
          state_d  = START;
        end
      end
      START: begin
        if (bit_done) begin
          clk_cnt_d = '0;
          tx_d      = shift_q[0];
          bit_idx_d = 3'd0;
          state_d   = DATA;
        end
      end
      DATA: begin
        if (bit_done) begin
          clk_cnt_d = '0;
          if (bit_idx_q == 3'd7) begin
            tx_d    = 1'b1;
            state_d = STOP;
          end else begin
            shift_d   = shift_q >> 1;
            tx_d      = shift_q[1];
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end
      end
      STOP: begin
        if (bit_done) begin
          clk_cnt_d = '0;
          // Chain straight into the next start bit so queued bytes leave no idle gap.
          if (!fifo_empty) begin
            fifo_pop = 1'b1;
            shift_d  = fifo_dout;
            tx_d     = 1'b0;
            state_d  = START;
          end else begin
            tx_d    = 1'b1;
            state_d = IDLE;
          end
        end
      end
      default: begin
        state_d = IDLE;
        tx_d    = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= IDLE;
      div_q     <= DIV_RESET;
      clk_cnt_q <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      tx_q      <= 1'b1;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      div_q     <= div_d;
      clk_cnt_q <= clk_cnt_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      tx_q      <= tx_d;
      ovf_q     <= ovf_d;
    end
  end

endmodule
